// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage access controller.
package mem_access_ctrl_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  localparam logic [1:0]  AlignMask = 2'b00;
  localparam logic [31:0] NopWord   = 32'h0;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Clearable up-counter with terminal-count flag; times how long an access waits for ack.
module mem_timeout_cnt #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned W       = $clog2(TIMEOUT)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [W-1:0] TcVal = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign tc_o = (r_cnt == TcVal);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage engine: issues one outstanding data-memory access at a time, stalls the
// front of the pipe while it waits, and aborts accesses that never see an ack.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned AW      = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   pc_i,
  input  logic [31:0]   instr_i,
  input  logic [31:0]   ALUResult_i,
  input  logic [31:0]   VALUResult_i,
  input  logic [31:0]   RDData_i,
  input  logic [4:0]    RDaddr_i,
  input  logic          RegWrite_i,
  input  logic          MemToReg_i,
  input  logic          MemRead_i,
  input  logic          MemWrite_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [31:0]   mem_rdata_i,
  output logic          stall_o,
  output logic [31:0]   pc_o,
  output logic [31:0]   instr_o,
  output logic [31:0]   ALUResult_o,
  output logic [31:0]   VALUResult_o,
  output logic [31:0]   MemData_o,
  output logic [4:0]    RDaddr_o,
  output logic          RegWrite_o,
  output logic          MemToReg_o,
  output logic          err_o
);

  state_e        r_state;
  logic          r_req, r_we, r_err;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_l_pc, r_l_instr, r_l_alu, r_l_valu;
  logic [4:0]    r_l_rd;
  logic          r_l_rw, r_l_m2r;
  logic [31:0]   r_pc, r_instr, r_alu, r_valu, r_mdata;
  logic [4:0]    r_rd;
  logic          r_rw, r_m2r;

  logic w_memop, w_misaligned, w_issue, w_busy, w_tc, w_done;

  assign w_memop      = MemRead_i | MemWrite_i;
  assign w_misaligned = w_memop & (ALUResult_i[1:0] != AlignMask);
  assign w_busy       = (r_state == StBusy);
  assign w_issue      = ~w_busy & w_memop & ~w_misaligned;
  assign w_done       = w_busy & (mem_ack_i | w_tc);

  // Reset gates the combinational stall so it drops with everything else.
  assign stall_o = ~rst_i & (w_busy ? ~(mem_ack_i | w_tc) : w_issue);

  mem_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (~w_busy | mem_ack_i | w_tc),
    .en_i  (w_busy),
    .tc_o  (w_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= NopWord;
      r_l_pc    <= NopWord;
      r_l_instr <= NopWord;
      r_l_alu   <= NopWord;
      r_l_valu  <= NopWord;
      r_l_rd    <= '0;
      r_l_rw    <= 1'b0;
      r_l_m2r   <= 1'b0;
      r_pc      <= NopWord;
      r_instr   <= NopWord;
      r_alu     <= NopWord;
      r_valu    <= NopWord;
      r_mdata   <= NopWord;
      r_rd      <= '0;
      r_rw      <= 1'b0;
      r_m2r     <= 1'b0;
    end else if (!w_busy) begin
      if (w_issue) begin
        r_state   <= StBusy;
        r_req     <= 1'b1;
        r_we      <= MemWrite_i;
        r_addr    <= AW'(ALUResult_i);
        r_wdata   <= RDData_i;
        r_l_pc    <= pc_i;
        r_l_instr <= instr_i;
        r_l_alu   <= ALUResult_i;
        r_l_valu  <= VALUResult_i;
        r_l_rd    <= RDaddr_i;
        r_l_rw    <= RegWrite_i;
        r_l_m2r   <= MemToReg_i;
        r_pc      <= NopWord;
        r_instr   <= NopWord;
        r_alu     <= NopWord;
        r_valu    <= NopWord;
        r_mdata   <= NopWord;
        r_rd      <= '0;
        r_rw      <= 1'b0;
        r_m2r     <= 1'b0;
      end else begin
        r_pc    <= pc_i;
        r_instr <= instr_i;
        r_alu   <= ALUResult_i;
        r_valu  <= VALUResult_i;
        r_mdata <= NopWord;
        r_rd    <= RDaddr_i;
        r_rw    <= RegWrite_i & ~w_misaligned;
        r_m2r   <= MemToReg_i;
        if (w_misaligned) r_err <= 1'b1;
      end
    end else if (w_done) begin
      // Ack beats a coincident timeout; only a pure timeout suppresses the write-back.
      r_state <= StIdle;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_pc    <= r_l_pc;
      r_instr <= r_l_instr;
      r_alu   <= r_l_alu;
      r_valu  <= r_l_valu;
      r_rd    <= r_l_rd;
      r_m2r   <= r_l_m2r;
      r_rw    <= r_l_rw & mem_ack_i;
      r_mdata <= (mem_ack_i && !r_we) ? mem_rdata_i : NopWord;
      if (!mem_ack_i) r_err <= 1'b1;
    end else begin
      r_pc    <= NopWord;
      r_instr <= NopWord;
      r_alu   <= NopWord;
      r_valu  <= NopWord;
      r_mdata <= NopWord;
      r_rd    <= '0;
      r_rw    <= 1'b0;
      r_m2r   <= 1'b0;
    end
  end

  assign mem_req_o    = r_req;
  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign pc_o         = r_pc;
  assign instr_o      = r_instr;
  assign ALUResult_o  = r_alu;
  assign VALUResult_o = r_valu;
  assign MemData_o    = r_mdata;
  assign RDaddr_o     = r_rd;
  assign RegWrite_o   = r_rw;
  assign MemToReg_o   = r_m2r;
  assign err_o        = r_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT=4 and a bench-driven memory port.
module tb_mem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i, instr_i, ALUResult_i, VALUResult_i, RDData_i;
  logic [4:0]  RDaddr_i;
  logic        RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [31:0] pc_o, instr_o, ALUResult_o, VALUResult_o, MemData_o;
  logic [4:0]  RDaddr_o;
  logic        RegWrite_o, MemToReg_o, err_o;

  int n_checks = 0;
  int n_pass   = 0;
  int stall_cnt, wr_cnt;

  always #5 clk_i = ~clk_i;

  mem_access_ctrl #(
    .TIMEOUT(4),
    .AW     (32)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pc_i        (pc_i),
    .instr_i     (instr_i),
    .ALUResult_i (ALUResult_i),
    .VALUResult_i(VALUResult_i),
    .RDData_i    (RDData_i),
    .RDaddr_i    (RDaddr_i),
    .RegWrite_i  (RegWrite_i),
    .MemToReg_i  (MemToReg_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_o     (stall_o),
    .pc_o        (pc_o),
    .instr_o     (instr_o),
    .ALUResult_o (ALUResult_o),
    .VALUResult_o(VALUResult_o),
    .MemData_o   (MemData_o),
    .RDaddr_o    (RDaddr_o),
    .RegWrite_o  (RegWrite_o),
    .MemToReg_o  (MemToReg_o),
    .err_o       (err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    pc_i = 0; instr_i = 0; ALUResult_i = 0; VALUResult_i = 0; RDData_i = 0;
    RDaddr_i = 0; RegWrite_i = 0; MemToReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd);
    clear_inputs();
    pc_i = 32'h80 + addr; instr_i = 32'h0000_2003; ALUResult_i = addr;
    RDaddr_i = rd; RegWrite_i = 1; MemToReg_i = 1; MemRead_i = 1;
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    #3;
    check_eq("rst_req", mem_req_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_stall", stall_o, 0);
    check_eq("rst_rw", RegWrite_o, 0);
    tick(); tick();
    rst_i = 1'b0;

    // ALU op passes straight through
    pc_i = 32'h40; instr_i = 32'h13; RegWrite_i = 1; ALUResult_i = 32'h1234; RDaddr_i = 5;
    VALUResult_i = 32'h7777;
    #1 check_eq("alu_stall", stall_o, 0);
    tick();
    check_eq("alu_rw", RegWrite_o, 1);
    check_eq("alu_res", ALUResult_o, 32'h1234);
    check_eq("alu_rd", RDaddr_o, 5);
    check_eq("alu_pc", pc_o, 32'h40);
    check_eq("alu_valu", VALUResult_o, 32'h7777);
    check_eq("alu_mdata", MemData_o, 0);
    check_eq("alu_req", mem_req_o, 0);
    clear_inputs();
    tick();

    // Load at 0x100, ack in the 4th BUSY cycle (coincides with terminal count)
    drive_load(32'h100, 7);
    stall_cnt = 0; wr_cnt = 0;
    #1 stall_cnt += int'(stall_o);
    tick();
    check_eq("ld_req", mem_req_o, 1);
    check_eq("ld_we", mem_we_o, 0);
    check_eq("ld_addr", mem_addr_o, 32'h100);
    check_eq("ld_bubble_instr", instr_o, 0);
    wr_cnt += int'(RegWrite_o);
    clear_inputs();
    RegWrite_i = 1; ALUResult_i = 32'hBAD0;  // noise that must be ignored while busy
    for (int k = 0; k < 4; k++) begin
      mem_ack_i   = (k == 3);
      mem_rdata_i = (k == 3) ? 32'hDEAD_BEEF : 32'h0;
      #1 stall_cnt += int'(stall_o);
      check_eq("ld_req_hold", mem_req_o, 1);
      tick();
      wr_cnt += int'(RegWrite_o);
    end
    clear_inputs();
    check_eq("ld_req_drop", mem_req_o, 0);
    check_eq("ld_mdata", MemData_o, 32'hDEAD_BEEF);
    check_eq("ld_m2r", MemToReg_o, 1);
    check_eq("ld_rw", RegWrite_o, 1);
    check_eq("ld_rd", RDaddr_o, 7);
    check_eq("ld_alu", ALUResult_o, 32'h100);
    check_eq("ld_pc", pc_o, 32'h180);
    check_eq("ld_err", err_o, 0);
    check_eq("ld_stall_cycles", stall_cnt, 4);
    tick();
    wr_cnt += int'(RegWrite_o);
    check_eq("ld_single_write", wr_cnt, 1);

    // Store with MemRead also set: treated as a write, ack in first BUSY cycle
    clear_inputs();
    ALUResult_i = 32'h8; RDData_i = 32'hA5A5_A5A5; MemWrite_i = 1; MemRead_i = 1;
    #1 check_eq("st_stall_issue", stall_o, 1);
    tick();
    check_eq("st_req", mem_req_o, 1);
    check_eq("st_we", mem_we_o, 1);
    check_eq("st_addr", mem_addr_o, 32'h8);
    check_eq("st_wdata", mem_wdata_o, 32'hA5A5_A5A5);
    RDData_i = 32'h0; ALUResult_i = 32'h0;
    mem_ack_i = 1; mem_rdata_i = 32'h1111_1111;
    #1 check_eq("st_stall_ack", stall_o, 0);
    check_eq("st_wdata_hold", mem_wdata_o, 32'hA5A5_A5A5);
    tick();
    clear_inputs();
    check_eq("st_req_drop", mem_req_o, 0);
    check_eq("st_mdata", MemData_o, 0);
    check_eq("st_rw", RegWrite_o, 0);

    // Misaligned load, then an aligned load that still works
    drive_load(32'h102, 3);
    #1 check_eq("mis_stall", stall_o, 0);
    tick();
    check_eq("mis_req", mem_req_o, 0);
    check_eq("mis_err", err_o, 1);
    check_eq("mis_rw", RegWrite_o, 0);
    check_eq("mis_mdata", MemData_o, 0);
    check_eq("mis_alu", ALUResult_o, 32'h102);
    drive_load(32'h104, 9);
    tick();
    check_eq("al_req", mem_req_o, 1);
    clear_inputs();
    mem_ack_i = 1; mem_rdata_i = 32'hCAFE_F00D;
    tick();
    clear_inputs();
    check_eq("al_mdata", MemData_o, 32'hCAFE_F00D);
    check_eq("al_rw", RegWrite_o, 1);
    check_eq("al_err_sticky", err_o, 1);

    // Asynchronous reset mid-BUSY, load left presented
    drive_load(32'h200, 4);
    tick();
    check_eq("rb_req", mem_req_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check_eq("rb_req_async", mem_req_o, 0);
    check_eq("rb_stall_async", stall_o, 0);
    check_eq("rb_err_async", err_o, 0);
    tick();
    rst_i = 1'b0;
    #1 check_eq("rb_stall_reissue", stall_o, 1);
    tick();
    check_eq("rb_req2", mem_req_o, 1);
    check_eq("rb_addr2", mem_addr_o, 32'h200);
    clear_inputs();
    mem_ack_i = 1; mem_rdata_i = 32'h0BAD_F00D;
    tick();
    clear_inputs();
    check_eq("rb_mdata", MemData_o, 32'h0BAD_F00D);
    check_eq("rb_rw", RegWrite_o, 1);

    // Timeout: no ack for 4 BUSY cycles
    drive_load(32'h300, 6);
    tick();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      #1 check_eq("to_stall", stall_o, (k == 3) ? 32'd0 : 32'd1);
      check_eq("to_req_hold", mem_req_o, 1);
      tick();
    end
    check_eq("to_req_drop", mem_req_o, 0);
    check_eq("to_err", err_o, 1);
    check_eq("to_rw", RegWrite_o, 0);
    check_eq("to_mdata", MemData_o, 0);
    check_eq("to_alu", ALUResult_o, 32'h300);
    mem_ack_i = 1; mem_rdata_i = 32'h55;
    #1 check_eq("late_stall", stall_o, 0);
    tick();
    clear_inputs();
    check_eq("late_req", mem_req_o, 0);
    check_eq("late_rw", RegWrite_o, 0);
    check_eq("late_mdata", MemData_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
